// File: rtl/ldr_avalon_wrapper.sv
// Order-10 Levinson-Durbin LPC engine behind an Avalon-MM register file.
// One shared 32x32 multiplier, 32-cycle restoring divider, status LEDs.

module ldr_rnd_sat (
  input  logic [31:0] a,
  output logic [15:0] q
);
  // Q4.27 -> Q3.12, round half up, clamp to int16
  logic signed [32:0] t;
  assign t = ($signed({a[31], a}) + 33'sd16384) >>> 15;
  always_comb begin
    q = t[15:0];
    if (t > 33'sd32767) q = 16'h7fff;
    else if (t < -33'sd32768) q = 16'h8000;
  end
endmodule

module ldr_avalon_wrapper (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [7:0]  led
);
  localparam int NC = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MAC, S_DIV, S_UPDATE, S_ENERGY, S_DONE
  } state_t;

  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    if (x > 64'sh0000_0000_7fff_ffff) return 32'sh7fff_ffff;
    if (x < -64'sh0000_0000_8000_0000) return 32'sh8000_0000;
    return x[31:0];
  endfunction

  function automatic logic signed [47:0] sat48(input logic [48:0] x);
    if (x[48] != x[47]) return x[48] ? {1'b1, 47'd0} : {1'b0, {47{1'b1}}};
    return x[47:0];
  endfunction

  state_t st_q, st_n;
  logic ctrl_q, start_q, done_q, err_q;
  logic [NC-1:0][15:0] r_q, ao_q, ao_rnd;
  logic [NC-1:0][31:0] a_q, aold_q;
  logic signed [31:0] e_q, k_q, om_q;
  logic signed [47:0] acc_q;
  logic [3:0]  i_q, j_q, ij, i_nx;
  logic [31:0] rem_q, num_q, quo_q;
  logic [4:0]  cnt_q;
  logic        ovf_q, neg_q, ph_q;

  logic busy, e_le0, launch, last;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod, prr, upd, kq27;
  logic [48:0] mac_sum;
  logic [47:0] acc_abs;
  logic [32:0] dtry;
  logic        qbit;
  logic [31:0] qnext, kmag;
  logic [15:0] rmux;

  assign busy   = st_q != S_IDLE;
  assign e_le0  = e_q <= 32'sd0;
  assign ij     = i_q - j_q;
  assign i_nx   = i_q + 4'd1;
  assign last   = j_q == i_q;
  assign launch = write && address == 16'h0001 && writedata[0] && !start_q && !busy && !ctrl_q;

  // operand steering for the single multiplier
  always_comb begin
    mul_a = k_q;
    mul_b = k_q;
    case (st_q)
      S_MAC: begin
        mul_a = a_q[j_q];
        mul_b = {{16{r_q[ij][15]}}, r_q[ij]};
      end
      S_UPDATE: begin
        mul_a = k_q;
        mul_b = aold_q[ij];
      end
      S_ENERGY: if (ph_q) begin
        mul_a = e_q;
        mul_b = om_q;
      end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prr     = (prod + 64'sd536870912) >>> 30;
  assign mac_sum = {acc_q[47], acc_q} + {prod[47], prod[47:0]};
  assign upd     = $signed({{32{a_q[j_q][31]}}, a_q[j_q]}) + prr;
  assign kq27    = ($signed({{32{k_q[31]}}, k_q}) + 64'sd4) >>> 3;

  // |acc| * 2^18 / E yields k magnitude in Q1.30
  assign acc_abs = acc_q[47] ? 48'(-acc_q) : acc_q;
  assign dtry    = {rem_q, num_q[31]};
  assign qbit    = dtry >= {1'b0, e_q};
  assign qnext   = {quo_q[30:0], qbit};
  assign kmag    = (ovf_q || qnext[31]) ? 32'h7fff_ffff : qnext;

  for (genvar g = 0; g < NC; g++) begin : g_lane
    ldr_rnd_sat u_rs (.a(a_q[g]), .q(ao_rnd[g]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_IDLE;
    else     st_q <= st_n;
  end

  always_comb begin
    st_n = st_q;
    if (ctrl_q) st_n = S_IDLE;
    else begin
      case (st_q)
        S_IDLE:   if (launch) st_n = S_INIT;
        S_INIT:   st_n = S_MAC;
        S_MAC:    if (last) st_n = e_le0 ? S_DONE : S_DIV;
        S_DIV:    if (cnt_q == 5'd31) st_n = S_UPDATE;
        S_UPDATE: if (last) st_n = S_ENERGY;
        S_ENERGY: if (ph_q) st_n = (i_q == 4'd10) ? S_DONE : S_MAC;
        S_DONE:   st_n = S_IDLE;
        default:  st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      ao_q    <= '0;
      a_q     <= '0;
      aold_q  <= '0;
      e_q     <= '0;
      k_q     <= '0;
      om_q    <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      if (write) begin
        if (address == 16'h0000) ctrl_q <= writedata[0];
        if (address == 16'h0001) start_q <= writedata[0];
        if (!busy && address >= 16'h0003 && address <= 16'h000d)
          r_q[4'(address[3:0] - 4'd3)] <= writedata;
      end
      if (ctrl_q) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ao_q   <= '0;
      end else begin
        case (st_q)
          S_IDLE: if (launch) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            i_q    <= '0;
          end
          S_INIT: begin
            e_q    <= {r_q[0][15], r_q[0], 15'd0};
            a_q    <= '0;
            a_q[0] <= 32'h0800_0000;
            i_q    <= 4'd1;
            j_q    <= 4'd1;
            acc_q  <= {{5{r_q[1][15]}}, r_q[1], 27'd0};
          end
          S_MAC: begin
            if (!last) begin
              acc_q <= sat48(mac_sum);
              j_q   <= j_q + 4'd1;
            end else if (e_le0) begin
              err_q <= 1'b1;
            end else begin
              neg_q <= acc_q[47];
              ovf_q <= acc_abs[47:14] >= {2'b00, e_q};
              rem_q <= acc_abs[45:14];
              num_q <= {acc_abs[13:0], 18'd0};
              quo_q <= '0;
              cnt_q <= '0;
            end
          end
          S_DIV: begin
            rem_q <= qbit ? 32'(dtry - {1'b0, e_q}) : dtry[31:0];
            num_q <= {num_q[30:0], 1'b0};
            quo_q <= qnext;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              k_q    <= neg_q ? $signed(kmag) : -$signed(kmag);
              aold_q <= a_q;
              j_q    <= 4'd1;
            end
          end
          S_UPDATE: begin
            if (!last) begin
              a_q[j_q] <= sat32(upd);
              j_q      <= j_q + 4'd1;
            end else begin
              a_q[i_q] <= sat32(kq27);
              ph_q     <= 1'b0;
            end
          end
          S_ENERGY: begin
            // first pass forms 1-k^2, second scales E by it
            if (!ph_q) begin
              om_q <= sat32(64'sd1073741824 - prr);
              ph_q <= 1'b1;
            end else begin
              e_q <= sat32(prr);
              if (i_q != 4'd10) begin
                i_q   <= i_nx;
                j_q   <= 4'd1;
                acc_q <= {{5{r_q[i_nx][15]}}, r_q[i_nx], 27'd0};
              end
            end
          end
          S_DONE: begin
            ao_q   <= ao_rnd;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rmux = '0;
    if (address == 16'h0000)      rmux = {15'd0, ctrl_q};
    else if (address == 16'h0001) rmux = {15'd0, start_q};
    else if (address == 16'h0002) rmux = {14'd0, err_q, done_q};
    else if (address >= 16'h0003 && address <= 16'h000d)
      rmux = r_q[4'(address[3:0] - 4'd3)];
    else if (address >= 16'h000e && address <= 16'h0018)
      rmux = ao_q[4'(address[4:0] - 5'd14)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       readdata <= '0;
    else if (read) readdata <= rmux;
  end

  assign led = {busy ? i_q : 4'd0, ctrl_q, err_q, busy, done_q};
endmodule

// File: tb/tb_ldr_avalon_wrapper.sv
// Bench for ldr_avalon_wrapper: vector table, corner sequences, and random
// autocorrelation sets checked against a double-precision Levinson model.

module tb_ldr_avalon_wrapper;
  logic        clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
  logic [15:0] address = '0, writedata = '0, readdata;
  logic [7:0]  led;
  int n_cmp = 0, n_bad = 0;

  typedef logic [10:0][15:0] vec11_t;
  typedef struct packed { vec11_t r; vec11_t a; logic err; } tv_t;
  tv_t tbl [4];

  int ar1    [11] = '{32767, 16384, 8192, 4096, 2048, 1024, 512, 256, 128, 64, 32};
  int speech [11] = '{32767, 25742, 16169, 9836, 4569, -2674, -11249, -17338, -14853, -6828, -3174};

  ldr_avalon_wrapper dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // plain Levinson-Durbin in doubles, outputs rounded to Q3.12
  function automatic void lev_model(input vec11_t r, output vec11_t a, output logic err);
    real rr[11], aa[11], an[11];
    real e, acc, k, x;
    for (int j = 0; j < 11; j++) begin
      rr[j] = real'(s16(r[j])) / 32768.0;
      aa[j] = 0.0;
    end
    aa[0] = 1.0;
    e = rr[0];
    err = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (e <= 0.0) begin
        err = 1'b1;
        break;
      end
      acc = rr[i];
      for (int j = 1; j < i; j++) acc += aa[j] * rr[i-j];
      k = -acc / e;
      an = aa;
      for (int j = 1; j < i; j++) an[j] = aa[j] + k * aa[i-j];
      an[i] = k;
      aa = an;
      e = e * (1.0 - k * k);
    end
    for (int j = 0; j < 11; j++) begin
      x = aa[j] * 4096.0;
      if (x > 32767.0) x = 32767.0;
      if (x < -32768.0) x = -32768.0;
      a[j] = 16'(rnd(x));
    end
  endfunction

  task automatic wr(input logic [15:0] ad, input logic [15:0] d);
    @(negedge clk);
    address = ad; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] ad, output logic [15:0] d);
    @(negedge clk);
    address = ad; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic kick();
    wr(16'h0001, 16'h0000);
    wr(16'h0001, 16'h0001);
  endtask

  task automatic wait_done(input string nm);
    logic [15:0] s;
    int cyc;
    s = '0;
    cyc = 0;
    while (!s[0] && cyc < 1000) begin
      rd(16'h0002, s);
      cyc++;
    end
    chk({nm, ".done_in_time"}, int'(s[0]), 1, 0);
  endtask

  task automatic load_r(input vec11_t r);
    for (int j = 0; j < 11; j++) wr(16'(3 + j), r[j]);
  endtask

  task automatic check_a(input string nm, input vec11_t exp, input logic exp_err);
    logic [15:0] d;
    rd(16'h0002, d);
    chk({nm, ".status"}, int'(d), exp_err ? 3 : 1, 0);
    for (int j = 0; j < 11; j++) begin
      rd(16'(14 + j), d);
      chk($sformatf("%s.A%0d", nm, j), s16(d), s16(exp[j]), (j == 0) ? 0 : 2);
    end
    rd(16'h0002, d);
    chk({nm, ".status_again"}, int'(d), exp_err ? 3 : 1, 0);
    chk({nm, ".led"}, int'(led), exp_err ? 5 : 1, 0);
  endtask

  task automatic run_vec(input string nm, input vec11_t r, input vec11_t exp, input logic exp_err);
    load_r(r);
    kick();
    wait_done(nm);
    check_a(nm, exp, exp_err);
  endtask

  task automatic rand_vec(output vec11_t r);
    real x[64];
    real c, r0, rk;
    int w;
    c = (real'(int'($urandom_range(0, 120))) - 60.0) / 100.0;
    for (int n = 0; n < 64; n++) begin
      w = int'($urandom_range(0, 2000)) - 1000;
      x[n] = real'(w) / 1000.0;
      if (n > 0) x[n] += c * x[n-1];
    end
    r0 = 0.0;
    for (int n = 0; n < 64; n++) r0 += x[n] * x[n];
    for (int k = 0; k < 11; k++) begin
      rk = 0.0;
      for (int n = 0; n + k < 64; n++) rk += x[n] * x[n+k];
      r[k] = 16'(rnd(32767.0 * rk / r0));
    end
  endtask

  initial begin
    logic [15:0] d;
    vec11_t ta, rv;
    logic te;

    for (int j = 0; j < 11; j++) begin
      tbl[0].r[j] = (j == 0) ? 16'd32767 : 16'd0;
      tbl[0].a[j] = (j == 0) ? 16'd4096 : 16'd0;
      tbl[1].r[j] = 16'(ar1[j]);
      tbl[1].a[j] = (j == 0) ? 16'd4096 : ((j == 1) ? 16'hf800 : 16'd0);
      tbl[2].r[j] = 16'(speech[j]);
      tbl[3].r[j] = 16'd0;
      tbl[3].a[j] = (j == 0) ? 16'd4096 : 16'd0;
    end
    tbl[0].err = 1'b0;
    tbl[1].err = 1'b0;
    lev_model(tbl[2].r, ta, te);
    tbl[2].a = ta;
    tbl[2].err = te;
    tbl[3].err = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset.led_in_rst", int'(led), 0, 0);
    rst = 1'b0;
    for (int ad = 0; ad < 32; ad++) begin
      rd(16'(ad), d);
      chk($sformatf("reset.rd%0d", ad), int'(d), 0, 0);
    end
    rd(16'h0100, d);
    chk("reset.rd_0x100", int'(d), 0, 0);
    chk("reset.led", int'(led), 0, 0);

    for (int t = 0; t < 4; t++)
      run_vec($sformatf("tbl%0d", t), tbl[t].r, tbl[t].a, tbl[t].err);

    // read-only and unmapped writes are ignored
    wr(16'h0002, 16'hffff);
    rd(16'h0002, d);
    chk("ro.status", int'(d), 3, 0);
    wr(16'h000e, 16'h1234);
    rd(16'h000e, d);
    chk("ro.A0", int'(d), 4096, 0);
    wr(16'h0040, 16'h0007);
    rd(16'h0040, d);
    chk("ro.unmapped", int'(d), 0, 0);

    // reads during busy return the previous results; R writes while busy dropped
    run_vec("prev", tbl[2].r, tbl[2].a, tbl[2].err);
    load_r(tbl[1].r);
    kick();
    chk("busy.led1", int'(led[1]), 1, 0);
    rd(16'h000f, d);
    chk("busy.A1_prev", s16(d), s16(tbl[2].a[1]), 2);
    wr(16'h0008, 16'd12345);
    wait_done("busy");
    rd(16'h0008, d);
    chk("busy.R5_kept", int'(d), ar1[5], 0);
    check_a("busy", tbl[1].a, 1'b0);

    // soft reset mid-computation
    load_r(tbl[2].r);
    kick();
    repeat (50) @(negedge clk);
    wr(16'h0000, 16'h0001);
    @(negedge clk);
    chk("soft.busy", int'(led[1]), 0, 0);
    chk("soft.done", int'(led[0]), 0, 0);
    chk("soft.led3", int'(led[3]), 1, 0);
    rd(16'h0002, d);
    chk("soft.status", int'(d), 0, 0);
    rd(16'h000e, d);
    chk("soft.A0", int'(d), 0, 0);
    rd(16'h000f, d);
    chk("soft.A1", int'(d), 0, 0);
    for (int j = 0; j < 11; j++) begin
      rd(16'(3 + j), d);
      chk($sformatf("soft.R%0d", j), s16(d), speech[j], 0);
    end
    kick();
    @(negedge clk);
    chk("soft.no_launch", int'(led[1]), 0, 0);
    wr(16'h0000, 16'h0000);
    kick();
    wait_done("soft_restart");
    check_a("soft_restart", tbl[2].a, tbl[2].err);

    // random filtered-noise autocorrelations
    for (int it = 0; it < 6; it++) begin
      rand_vec(rv);
      lev_model(rv, ta, te);
      run_vec($sformatf("rand%0d", it), rv, ta, te);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
